affine_loop_ctrl_3d: RTL and testbench

- Schedule controller that generates the per-iteration enable and 3-deep loop index vector (ctrl_vars) for one compute op.
- Sits directly upstream of a unified buffer port. Drives its write_wen/read_ren and write_ctrl_vars/read_ctrl_vars [2:0].
- A flush pulse starts a fixed-latency affine schedule: start offset, then one iteration every II cycles, walking root/y/x extents.

---
 rtl/affine_loop_ctrl_3d.sv | 98 +++++++++
 tb/tb_affine_loop_ctrl_3d.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/affine_loop_ctrl_3d.sv
// affine_loop_ctrl_3d: affine schedule controller issuing valid + 3-deep loop indices to a unified buffer port
// Ports: clk, rst (async, active-high), flush (restart pulse), stall (freeze),
//        valid (iteration enable), ctrl_vars[0]=root [1]=x [2]=y, done (sticky completion).
// Optional: define AFFINE_LOOP_CTRL_LINADDR_EN to add linear_addr = x + y*X + root*X*Y, kept incrementally.
module affine_loop_ctrl_3d #(
  parameter int CTRL_W       = 16,
  parameter int X_EXTENT     = 64,
  parameter int Y_EXTENT     = 64,
  parameter int ROOT_EXTENT  = 1,
  parameter int START_OFFSET = 0,
  parameter int II           = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              stall,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl_vars [2:0],
  output logic              done
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
  , output logic [CTRL_W-1:0] linear_addr
`endif
);
  typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;
  localparam logic [CTRL_W-1:0] XL = CTRL_W'(X_EXTENT - 1);
  localparam logic [CTRL_W-1:0] YL = CTRL_W'(Y_EXTENT - 1);
  localparam logic [CTRL_W-1:0] RL = CTRL_W'(ROOT_EXTENT - 1);
  localparam logic [CTRL_W-1:0] DL = CTRL_W'((START_OFFSET > 0) ? START_OFFSET - 1 : 0);
  localparam logic [CTRL_W-1:0] IL = CTRL_W'(II - 1);
  state_t state;
  logic [CTRL_W-1:0] px, py, pr, dcnt, iic;
  logic [CTRL_W-1:0] sx, sy, sr, nx, ny, nr;
  logic go, last;
  // p* hold the pending iteration; a flush makes iteration 0 pending in the same cycle
  always_comb begin
    sx   = flush ? '0 : px;
    sy   = flush ? '0 : py;
    sr   = flush ? '0 : pr;
    last = (sx == XL) && (sy == YL) && (sr == RL);
    nx   = (sx == XL) ? '0 : sx + 1'b1;
    ny   = (sx != XL) ? sy : (sy == YL) ? '0 : sy + 1'b1;
    nr   = (sx != XL || sy != YL) ? sr : (sr == RL) ? '0 : sr + 1'b1;
    go   = flush ? (START_OFFSET == 0)
                 : !stall && ((state == RUN && iic == '0) || (state == DELAY && dcnt == DL));
  end
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
  logic [CTRL_W-1:0] pa, sa;
  assign sa = flush ? '0 : pa;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      valid <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 3; i++) ctrl_vars[i] <= '0;
      px    <= '0;
      py    <= '0;
      pr    <= '0;
      dcnt  <= '0;
      iic   <= '0;
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
      pa          <= '0;
      linear_addr <= '0;
`endif
    end else begin
      valid <= go;
      if (flush) begin
        state <= DELAY;
        done  <= 1'b0;
        dcnt  <= '0;
        iic   <= '0;
        px    <= '0;
        py    <= '0;
        pr    <= '0;
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
        pa    <= '0;
`endif
      end else if (state == DONE) done <= 1'b1;
      else if (!stall && state == DELAY) dcnt <= dcnt + 1'b1;
      else if (!stall && state == RUN) iic <= (iic == IL) ? '0 : iic + 1'b1;
      // issuing an iteration: publish pending indices, advance them, restart the II phase
      if (go) begin
        ctrl_vars[0] <= sr;
        ctrl_vars[1] <= sx;
        ctrl_vars[2] <= sy;
        px           <= nx;
        py           <= ny;
        pr           <= nr;
        iic          <= CTRL_W'(II > 1);
        state        <= last ? DONE : RUN;
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
        linear_addr  <= sa;
        pa           <= sa + 1'b1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_affine_loop_ctrl_3d.sv
// tb_affine_loop_ctrl_3d: self-checking bench for affine_loop_ctrl_3d (default and offset/II configs)
module tb_affine_loop_ctrl_3d;
  localparam int CW = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] flush = '0, stall = '0, valid, done;
  logic [CW-1:0] cva [2:0];
  logic [CW-1:0] cvb [2:0];
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
  logic [CW-1:0] la_a, la_b;
`endif
  always #5 clk = ~clk;
  affine_loop_ctrl_3d u_a (
    .clk(clk), .rst(rst), .flush(flush[0]), .stall(stall[0]),
    .valid(valid[0]), .ctrl_vars(cva), .done(done[0])
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
    , .linear_addr(la_a)
`endif
  );
  affine_loop_ctrl_3d #(.X_EXTENT(4), .Y_EXTENT(2), .ROOT_EXTENT(2), .START_OFFSET(5), .II(3)) u_b (
    .clk(clk), .rst(rst), .flush(flush[1]), .stall(stall[1]),
    .valid(valid[1]), .ctrl_vars(cvb), .done(done[1])
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
    , .linear_addr(la_b)
`endif
  );
  int xe [2] = '{64, 4};
  int ye [2] = '{64, 2};
  int re [2] = '{1, 2};
  int so [2] = '{0, 5};
  int ii [2] = '{1, 3};
  int ne [2], issued [2];
  bit act [2], dexp [2];
  int n_cmp = 0, n_bad = 0;
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // Model: issues land on the (S + j*II)-th unstalled edge after flush (flush edge is 0);
  // done rises on the edge after the last issue.
  task automatic tick();
    logic [1:0] f, s;
    bit ev [2];
    int n, k;
    f = flush;
    s = stall;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      n = xe[d] * ye[d] * re[d];
      ev[d] = 1'b0;
      if (f[d]) begin
        act[d] = 1'b1; ne[d] = 0; issued[d] = 0; dexp[d] = 1'b0;
        ev[d] = (so[d] == 0);
      end else if (act[d]) begin
        if (issued[d] == n) dexp[d] = 1'b1;
        if (!s[d]) ne[d]++;
        ev[d] = !s[d] && issued[d] < n && ne[d] >= so[d] && (ne[d] - so[d]) % ii[d] == 0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk(d ? "valid_b" : "valid_a", 64'(valid[d]), 64'(ev[d]));
      chk(d ? "done_b" : "done_a", 64'(done[d]), 64'(dexp[d]));
      if (ev[d]) begin
        k = issued[d];
        chk(d ? "x_b" : "x_a", 64'(d ? cvb[1] : cva[1]), 64'(k % xe[d]));
        chk(d ? "y_b" : "y_a", 64'(d ? cvb[2] : cva[2]), 64'((k / xe[d]) % ye[d]));
        chk(d ? "root_b" : "root_a", 64'(d ? cvb[0] : cva[0]), 64'(k / (xe[d] * ye[d])));
`ifdef AFFINE_LOOP_CTRL_LINADDR_EN
        chk(d ? "laddr_b" : "laddr_a", 64'(d ? la_b : la_a), 64'(k));
`endif
        issued[d]++;
      end
    end
    flush = '0;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_valid"}, 64'(valid), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_cva"}, 64'(cva[i]), 64'(0));
      chk({tag, "_cvb"}, 64'(cvb[i]), 64'(0));
    end
  endtask
  task automatic run_until(int d, int target);
    int g = 0;
    while (issued[d] < target && g < 20000) begin
      tick();
      g++;
    end
    chk("reach_target", 64'(issued[d] >= target), 64'(1));
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin act[d] = 0; dexp[d] = 0; ne[d] = 0; issued[d] = 0; end
    #2;
    chk_zero("reset");
    #10;
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk_zero("idle");
    end
    flush = 2'b11;
    repeat (4105) tick();
    chk("cnt_a_default", 64'(issued[0]), 64'(4096));
    chk("cnt_b_default", 64'(issued[1]), 64'(16));
    flush[0] = 1'b1;
    tick();
    run_until(0, 10);
    stall[0] = 1'b1;
    repeat (7) tick();
    stall[0] = 1'b0;
    repeat (4100) tick();
    flush[0] = 1'b1;
    tick();
    run_until(0, 17 * 64 + 6);
    flush[0] = 1'b1;
    tick();
    repeat (500) tick();
    flush[0] = 1'b1;
    stall[0] = 1'b1;
    tick();
    repeat (2) tick();
    stall[0] = 1'b0;
    repeat (4100) tick();
    for (int c = 0; c < 3000; c++) begin
      stall[0] = ($urandom_range(0, 3) == 0);
      stall[1] = ($urandom_range(0, 2) == 0);
      flush[0] = ($urandom_range(0, 999) == 0);
      flush[1] = ($urandom_range(0, 60) == 0);
      tick();
    end
    stall = '0;
    flush = 2'b11;
    tick();
    repeat (40) tick();
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    #3 rst = 1'b0;
    for (int d = 0; d < 2; d++) begin act[d] = 0; dexp[d] = 0; end
    repeat (5) begin
      tick();
      chk_zero("post_rst");
    end
    flush = 2'b11;
    repeat (100) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
